// File: rtl/spi0_txn_arbiter.sv
// Round-robin arbiter sharing one SPI mode-0 master between two byte streams.
// Grants whole transactions; sequences CS setup, byte shifting and CS hold.
module spi0_txn_arbiter #(
  parameter int CLK_DIV = 2
) (
  input  logic       clk_clk,
  input  logic       reset_reset_n,
  input  logic       req0,
  input  logic       req1,
  output logic       gnt0,
  output logic       gnt1,
  input  logic       tx_valid0,
  input  logic       tx_valid1,
  input  logic [7:0] tx_data0,
  input  logic [7:0] tx_data1,
  output logic       tx_ready0,
  output logic       tx_ready1,
  output logic       rx_valid0,
  output logic       rx_valid1,
  output logic [7:0] rx_data,
  input  logic       spi0_MISO,
  output logic       spi0_MOSI,
  output logic       spi0_SCLK,
  output logic       spi0_SS_n
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    WAIT_BYTE,
    SHIFT,
    HOLD
  } state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2:0]     bit_q, bit_d;
  logic [1:0]     gnt_q, gnt_d;
  logic           cur_q, cur_d;
  logic           last_q, last_d;
  logic           ss_n_q, ss_n_d;
  logic           sclk_q, sclk_d;
  logic           mosi_q, mosi_d;
  logic [7:0]     tx_sh_q, tx_sh_d;
  logic [7:0]     rx_sh_q, rx_sh_d;
  logic [7:0]     rx_data_q, rx_data_d;
  logic [1:0]     rx_vld_q, rx_vld_d;

  logic       cnt_last;
  logic       win;
  logic       sel_req;
  logic       sel_vld;
  logic [7:0] sel_dat;

  assign cnt_last = (cnt_q == CW'(CLK_DIV - 1));
  // On contention the requester not granted last wins
  assign win      = !(req0 && (!req1 || last_q));
  assign sel_req  = cur_q ? req1 : req0;
  assign sel_vld  = cur_q ? tx_valid1 : tx_valid0;
  assign sel_dat  = cur_q ? tx_data1 : tx_data0;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      gnt_q     <= '0;
      cur_q     <= 1'b0;
      last_q    <= 1'b1;
      ss_n_q    <= 1'b1;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      tx_sh_q   <= '0;
      rx_sh_q   <= '0;
      rx_data_q <= '0;
      rx_vld_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      gnt_q     <= gnt_d;
      cur_q     <= cur_d;
      last_q    <= last_d;
      ss_n_q    <= ss_n_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      tx_sh_q   <= tx_sh_d;
      rx_sh_q   <= rx_sh_d;
      rx_data_q <= rx_data_d;
      rx_vld_q  <= rx_vld_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    gnt_d     = gnt_q;
    cur_d     = cur_q;
    last_d    = last_q;
    ss_n_d    = ss_n_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    tx_sh_d   = tx_sh_q;
    rx_sh_d   = rx_sh_q;
    rx_data_d = rx_data_q;
    rx_vld_d  = '0;
    unique case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          cur_d   = win;
          last_d  = win;
          gnt_d   = win ? 2'b10 : 2'b01;
          ss_n_d  = 1'b0;
          cnt_d   = '0;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (cnt_last) begin
          cnt_d   = '0;
          state_d = WAIT_BYTE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WAIT_BYTE: begin
        if (sel_vld) begin
          tx_sh_d = {sel_dat[6:0], 1'b0};
          mosi_d  = sel_dat[7];
          sclk_d  = 1'b0;
          cnt_d   = '0;
          bit_d   = '0;
          state_d = SHIFT;
        end else if (!sel_req) begin
          ss_n_d  = 1'b1;
          gnt_d   = '0;
          mosi_d  = 1'b0;
          cnt_d   = '0;
          state_d = HOLD;
        end
      end
      SHIFT: begin
        if (!cnt_last) begin
          cnt_d = cnt_q + CW'(1);
        end else if (!sclk_q) begin
          cnt_d   = '0;
          sclk_d  = 1'b1;
          rx_sh_d = {rx_sh_q[6:0], spi0_MISO};
        end else begin
          cnt_d  = '0;
          sclk_d = 1'b0;
          if (bit_q == 3'd7) begin
            rx_data_d = rx_sh_q;
            rx_vld_d  = gnt_q;
            state_d   = WAIT_BYTE;
          end else begin
            bit_d   = bit_q + 3'd1;
            mosi_d  = tx_sh_q[7];
            tx_sh_d = {tx_sh_q[6:0], 1'b0};
          end
        end
      end
      HOLD: begin
        if (cnt_last) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign gnt0      = gnt_q[0];
  assign gnt1      = gnt_q[1];
  assign tx_ready0 = (state_q == WAIT_BYTE) && gnt_q[0];
  assign tx_ready1 = (state_q == WAIT_BYTE) && gnt_q[1];
  assign rx_valid0 = rx_vld_q[0];
  assign rx_valid1 = rx_vld_q[1];
  assign rx_data   = rx_data_q;
  assign spi0_MOSI = mosi_q;
  assign spi0_SCLK = sclk_q;
  assign spi0_SS_n = ss_n_q;

endmodule

// File: tb/tb_spi0_txn_arbiter.sv
// Directed bench for spi0_txn_arbiter with a mode-0 slave model.
// Covers reset, single byte, round-robin, burst, request drop, async reset.
module tb_spi0_txn_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0, req1;
  logic       gnt0, gnt1;
  logic       tx_valid0, tx_valid1;
  logic [7:0] tx_data0, tx_data1;
  logic       tx_ready0, tx_ready1;
  logic       rx_valid0, rx_valid1;
  logic [7:0] rx_data;
  logic       miso, mosi, sclk, ss_n;

  int errors = 0;
  int checks = 0;

  int         rise_cnt = 0;
  int         base = 0;
  int         rel;
  logic [7:0] sresp [4];
  logic [7:0] mosi_sh = 8'h00;
  logic       both_seen = 1'b0;

  spi0_txn_arbiter #(.CLK_DIV(2)) dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .req0          (req0),
    .req1          (req1),
    .gnt0          (gnt0),
    .gnt1          (gnt1),
    .tx_valid0     (tx_valid0),
    .tx_valid1     (tx_valid1),
    .tx_data0      (tx_data0),
    .tx_data1      (tx_data1),
    .tx_ready0     (tx_ready0),
    .tx_ready1     (tx_ready1),
    .rx_valid0     (rx_valid0),
    .rx_valid1     (rx_valid1),
    .rx_data       (rx_data),
    .spi0_MISO     (miso),
    .spi0_MOSI     (mosi),
    .spi0_SCLK     (sclk),
    .spi0_SS_n     (ss_n)
  );

  always #5 clk = ~clk;

  always @(posedge sclk) begin
    rise_cnt <= rise_cnt + 1;
    mosi_sh  <= {mosi_sh[6:0], mosi};
  end

  // Slave presents the next response bit after each rising SCLK
  always_comb begin
    rel  = rise_cnt - base;
    miso = sresp[rel[4:3]][3'd7 - rel[2:0]];
  end

  always @(negedge clk) if (gnt0 && gnt1) both_seen <= 1'b1;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    tick();
    checks++;
    if ({gnt0, gnt1} !== 2'b00) begin
      errors++;
      $display("FAIL reset_gnt got=%b want=00", {gnt0, gnt1});
    end
    checks++;
    if ({tx_ready0, tx_ready1, rx_valid0, rx_valid1} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_rdy_vld got=%b want=0000",
               {tx_ready0, tx_ready1, rx_valid0, rx_valid1});
    end
    checks++;
    if ({ss_n, sclk, mosi} !== 3'b100) begin
      errors++;
      $display("FAIL reset_pins got=%b want=100", {ss_n, sclk, mosi});
    end
    checks++;
    if (rx_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_rx_data got=%h want=00", rx_data);
    end
  endtask

  task automatic test_single_byte();
    sresp[0] = 8'h3C;
    req0 = 1'b1;
    tick();
    checks++;
    if ({gnt0, ss_n} !== 2'b10) begin
      errors++;
      $display("FAIL single_grant gnt0,ss_n got=%b want=10", {gnt0, ss_n});
    end
    tick();
    checks++;
    if (tx_ready0 !== 1'b0) begin
      errors++;
      $display("FAIL single_ready_g1 got=%b want=0", tx_ready0);
    end
    tick();
    checks++;
    if (tx_ready0 !== 1'b1) begin
      errors++;
      $display("FAIL single_ready_g2 got=%b want=1", tx_ready0);
    end
    base = rise_cnt;
    tx_valid0 = 1'b1;
    tx_data0 = 8'hA5;
    tick();
    tx_valid0 = 1'b0;
    repeat (31) tick();
    checks++;
    if (rx_valid0 !== 1'b0) begin
      errors++;
      $display("FAIL single_rx_early got=%b want=0", rx_valid0);
    end
    tick();
    checks++;
    if (rx_valid0 !== 1'b1 || rx_data !== 8'h3C) begin
      errors++;
      $display("FAIL single_rx got vld=%b data=%h want vld=1 data=3c",
               rx_valid0, rx_data);
    end
    checks++;
    if (rise_cnt - base != 8 || mosi_sh !== 8'hA5) begin
      errors++;
      $display("FAIL single_sclk_mosi got pulses=%0d mosi=%h want 8 a5",
               rise_cnt - base, mosi_sh);
    end
    tick();
    checks++;
    if (rx_valid0 !== 1'b0) begin
      errors++;
      $display("FAIL single_rx_pulse got=%b want=0", rx_valid0);
    end
    req0 = 1'b0;
    tick();
    checks++;
    if ({ss_n, gnt0} !== 2'b10) begin
      errors++;
      $display("FAIL single_release ss_n,gnt0 got=%b want=10", {ss_n, gnt0});
    end
    repeat (5) tick();
  endtask

  task automatic test_round_robin();
    int hi;
    int n;
    do_reset();
    req0 = 1'b1;
    req1 = 1'b1;
    tick();
    checks++;
    if ({gnt0, gnt1} !== 2'b10) begin
      errors++;
      $display("FAIL rr_first got=%b want=10", {gnt0, gnt1});
    end
    req0 = 1'b0;
    hi = 0;
    n = 0;
    while (!gnt1 && n < 20) begin
      tick();
      n++;
      if (ss_n) hi++;
    end
    checks++;
    if (gnt1 !== 1'b1 || gnt0 !== 1'b0 || hi != 3) begin
      errors++;
      $display("FAIL rr_second gnt1=%b gnt0=%b gap=%0d want 1 0 3",
               gnt1, gnt0, hi);
    end
    req0 = 1'b1;
    req1 = 1'b0;
    n = 0;
    while (!ss_n && n < 20) begin
      tick();
      n++;
    end
    req1 = 1'b1;
    n = 0;
    while (!(gnt0 || gnt1) && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if ({gnt0, gnt1} !== 2'b10) begin
      errors++;
      $display("FAIL rr_third got=%b want=10", {gnt0, gnt1});
    end
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (8) tick();
    checks++;
    if (both_seen !== 1'b0 || {gnt0, gnt1, ss_n} !== 3'b001) begin
      errors++;
      $display("FAIL rr_exclusive both=%b gnt=%b ss_n=%b want 0 00 1",
               both_seen, {gnt0, gnt1}, ss_n);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    int nhs;
    int nrx;
    int sshi;
    int hs_t [3];
    logic [7:0] rxv [3];
    logic hs;
    sresp[0] = 8'h11;
    sresp[1] = 8'h22;
    sresp[2] = 8'h33;
    base = rise_cnt;
    cyc = 0;
    nhs = 0;
    nrx = 0;
    sshi = 0;
    req0 = 1'b1;
    tx_valid0 = 1'b1;
    tx_data0 = 8'h01;
    while (nrx < 3 && cyc < 400) begin
      hs = tx_ready0 && tx_valid0;
      tick();
      cyc++;
      if (hs && nhs < 3) begin
        hs_t[nhs] = cyc;
        nhs++;
        if (nhs == 3) tx_valid0 = 1'b0;
        else tx_data0 = 8'(nhs + 1);
      end
      if (rx_valid0) begin
        rxv[nrx] = rx_data;
        nrx++;
      end
      if (gnt0 && ss_n) sshi++;
    end
    checks++;
    if (nhs != 3 || nrx != 3) begin
      errors++;
      $display("FAIL burst_count hs=%0d rx=%0d want 3 3", nhs, nrx);
    end else begin
      checks++;
      if (hs_t[1] - hs_t[0] != 33 || hs_t[2] - hs_t[1] != 33) begin
        errors++;
        $display("FAIL burst_pitch got=%0d,%0d want 33,33",
                 hs_t[1] - hs_t[0], hs_t[2] - hs_t[1]);
      end
      checks++;
      if (rxv[0] !== 8'h11 || rxv[1] !== 8'h22 || rxv[2] !== 8'h33) begin
        errors++;
        $display("FAIL burst_rx got=%h %h %h want 11 22 33",
                 rxv[0], rxv[1], rxv[2]);
      end
    end
    checks++;
    if (rise_cnt - base != 24 || sshi != 0 || mosi_sh !== 8'h03) begin
      errors++;
      $display("FAIL burst_bus pulses=%0d ss_hi=%0d mosi=%h want 24 0 03",
               rise_cnt - base, sshi, mosi_sh);
    end
    req0 = 1'b0;
    repeat (6) tick();
  endtask

  task automatic test_req_drop();
    int n;
    sresp[0] = 8'h96;
    base = rise_cnt;
    req1 = 1'b1;
    tx_valid1 = 1'b1;
    tx_data1 = 8'h5A;
    n = 0;
    while (!(tx_ready1 && tx_valid1) && n < 50) begin
      tick();
      n++;
    end
    tick();
    tx_valid1 = 1'b0;
    n = 0;
    while (rise_cnt - base < 4 && n < 50) begin
      tick();
      n++;
    end
    req1 = 1'b0;
    n = 0;
    while (!rx_valid1 && n < 60) begin
      tick();
      n++;
    end
    checks++;
    if (rx_valid1 !== 1'b1 || rx_data !== 8'h96 || ss_n !== 1'b0) begin
      errors++;
      $display("FAIL drop_rx vld=%b data=%h ss_n=%b want 1 96 0",
               rx_valid1, rx_data, ss_n);
    end
    tick();
    checks++;
    if ({ss_n, gnt1} !== 2'b10) begin
      errors++;
      $display("FAIL drop_release ss_n,gnt1 got=%b want=10", {ss_n, gnt1});
    end
    repeat (10) tick();
    checks++;
    if (rise_cnt - base != 8 || mosi_sh !== 8'h5A) begin
      errors++;
      $display("FAIL drop_pulses got=%0d mosi=%h want 8 5a",
               rise_cnt - base, mosi_sh);
    end
  endtask

  task automatic test_async_reset();
    int n;
    logic rx_seen;
    base = rise_cnt;
    req0 = 1'b1;
    tx_valid0 = 1'b1;
    tx_data0 = 8'hFF;
    n = 0;
    while (!(tx_ready0 && tx_valid0) && n < 50) begin
      tick();
      n++;
    end
    tick();
    tx_valid0 = 1'b0;
    n = 0;
    while (rise_cnt - base < 6 && n < 50) begin
      tick();
      n++;
    end
    #2;
    rst_n = 1'b0;
    req0 = 1'b0;
    #1;
    checks++;
    if ({ss_n, sclk, gnt0} !== 3'b100) begin
      errors++;
      $display("FAIL areset_pins ss_n,sclk,gnt0 got=%b want=100",
               {ss_n, sclk, gnt0});
    end
    rx_seen = 1'b0;
    repeat (3) begin
      tick();
      if (rx_valid0 || rx_valid1) rx_seen = 1'b1;
    end
    rst_n = 1'b1;
    req1 = 1'b1;
    repeat (2) begin
      tick();
      if (rx_valid0 || rx_valid1) rx_seen = 1'b1;
    end
    checks++;
    if (rx_seen !== 1'b0 || {gnt0, gnt1} !== 2'b01) begin
      errors++;
      $display("FAIL areset_regrant rx=%b gnt=%b want 0 01",
               rx_seen, {gnt0, gnt1});
    end
    sresp[0] = 8'hE7;
    tx_valid1 = 1'b1;
    tx_data1 = 8'hC3;
    n = 0;
    while (!(tx_ready1 && tx_valid1) && n < 50) begin
      tick();
      n++;
    end
    base = rise_cnt;
    tick();
    tx_valid1 = 1'b0;
    n = 0;
    while (!rx_valid1 && n < 60) begin
      tick();
      n++;
    end
    checks++;
    if (rx_valid1 !== 1'b1 || rx_data !== 8'hE7 || mosi_sh !== 8'hC3 ||
        rise_cnt - base != 8) begin
      errors++;
      $display("FAIL areset_xfer vld=%b rx=%h mosi=%h pulses=%0d want 1 e7 c3 8",
               rx_valid1, rx_data, mosi_sh, rise_cnt - base);
    end
    req1 = 1'b0;
    repeat (6) tick();
  endtask

  initial begin
    rst_n = 1'b0;
    req0 = 1'b0;
    req1 = 1'b0;
    tx_valid0 = 1'b0;
    tx_valid1 = 1'b0;
    tx_data0 = 8'h00;
    tx_data1 = 8'h00;
    for (int i = 0; i < 4; i++) sresp[i] = 8'h00;
    test_reset();
    test_single_byte();
    test_round_robin();
    test_back_to_back();
    test_req_drop();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
